// File: rtl/audio_fir_decim_pkg.sv
// Shared constants and fixed-point helpers for the audio decimating FIR.
package audio_fir_decim_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned QUANT_BITS  = 10;
  localparam int unsigned AUDIO_DECIM = 8;
  localparam int unsigned MAX_TAPS    = 32;

  // Symmetric low-pass taps in Q10.
  localparam logic signed [DATA_WIDTH-1:0] AUDIO_LPR_COEFFS [MAX_TAPS] = '{
    1, 2, 3, 5, 8, 12, 17, 24, 32, 41, 50, 59, 67, 74, 78, 80,
    80, 78, 74, 67, 59, 50, 41, 32, 24, 17, 12, 8, 5, 3, 2, 1
  };

  // Q10 -> integer, rounding toward zero: negative values get a bias before the shift.
  function automatic logic signed [DATA_WIDTH-1:0] DEQUANTIZE_I(
    input logic signed [DATA_WIDTH-1:0] v
  );
    logic signed [DATA_WIDTH-1:0] biased;
    biased = v[DATA_WIDTH-1] ? v + DATA_WIDTH'((1 << QUANT_BITS) - 1) : v;
    return biased >>> QUANT_BITS;
  endfunction

endpackage

// File: rtl/audio_fir_decim_fir_mac.sv
// One-tap-per-cycle multiply / dequantize / accumulate datapath with clear and enable.
module audio_fir_decim_fir_mac
  import audio_fir_decim_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] coeff_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  output logic signed [DATA_WIDTH-1:0] acc_o
);

  logic signed [DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0] acc_d, acc_q;

  always_comb begin
    // Evaluated at DATA_WIDTH, so only the low half of the full product survives.
    prod  = coeff_i * sample_i;
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + DEQUANTIZE_I(prod);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/audio_fir_decim.sv
// Streaming decimating FIR: fill DECIM samples, run TAPS MAC cycles, hold result until taken.
module audio_fir_decim
  import audio_fir_decim_pkg::*;
#(
  parameter int unsigned                  TAPS           = MAX_TAPS,
  parameter int unsigned                  DECIM          = AUDIO_DECIM,
  parameter logic signed [DATA_WIDTH-1:0] COEFFS [TAPS]  = AUDIO_LPR_COEFFS
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned PtrW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned KW   = $clog2(TAPS + 1);
  localparam int unsigned CntW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PtrW-1:0] PtrMask = PtrW'(TAPS - 1);

  typedef enum logic [1:0] {StFill, StMac, StOut} state_e;

  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] hist_q [TAPS];
  logic [PtrW-1:0]              wp_q, wp_d, rd_idx;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [KW-1:0]                k_q, k_d;
  logic signed [DATA_WIDTH-1:0] dout_q, dout_d, acc;
  logic                         out_valid_q, out_valid_d;
  logic                         in_ready_q, in_ready_d;
  logic                         hist_we, mac_clr, mac_en;

  // hist[wp-1] is the newest sample; tap k reads k samples further back.
  assign rd_idx = (wp_q - PtrW'(1) - k_q[PtrW-1:0]) & PtrMask;

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    hist_we     = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    unique case (state_q)
      StFill: begin
        if (in_valid && in_ready_q) begin
          hist_we = 1'b1;
          wp_d    = (wp_q + PtrW'(1)) & PtrMask;
          if (cnt_q == CntW'(DECIM - 1)) begin
            cnt_d   = '0;
            k_d     = '0;
            mac_clr = 1'b1;
            state_d = StMac;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StMac: begin
        // One extra cycle after the last tap lets the accumulator settle into dout.
        if (k_q == KW'(TAPS)) begin
          dout_d      = acc;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end else begin
          mac_en = 1'b1;
          k_d    = k_q + KW'(1);
        end
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StFill;
        end
      end
      default: state_d = StFill;
    endcase
    in_ready_d = (state_d == StFill);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StFill;
      hist_q      <= '{default: '0};
      wp_q        <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      if (hist_we) begin
        hist_q[wp_q] <= din;
      end
    end
  end

  audio_fir_decim_fir_mac u_fir_mac (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .clr_i    (mac_clr),
    .en_i     (mac_en),
    .coeff_i  (COEFFS[k_q[PtrW-1:0]]),
    .sample_i (hist_q[rd_idx]),
    .acc_o    (acc)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_audio_fir_decim.sv
// Bench for audio_fir_decim: four coefficient sets run in lockstep against a direct-form model.
module tb_audio_fir_decim;
  import audio_fir_decim_pkg::*;

  localparam int NS = 4;

  localparam logic signed [DATA_WIDTH-1:0] C_STEP [MAX_TAPS] = '{default: 1024};
  localparam logic signed [DATA_WIDTH-1:0] C_IMP [MAX_TAPS] = '{
    1024, 2048, 3072, 4096, 5120, 6144, 7168, 8192, 9216, 10240, 11264, 12288, 13312, 14336,
    15360, 16384, 17408, 18432, 19456, 20480, 21504, 22528, 23552, 24576, 25600, 26624, 27648,
    28672, 29696, 30720, 31744, 32768
  };
  localparam logic signed [DATA_WIDTH-1:0] C_RND [MAX_TAPS] = '{0: 512, default: 0};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                         reset_n, in_valid, out_ready;
  logic signed [DATA_WIDTH-1:0] din;
  logic signed [DATA_WIDTH-1:0] dout_a [NS];
  logic                         in_ready_a [NS];
  logic                         out_valid_a [NS];

  audio_fir_decim u_lpr (
    .clock(clock), .reset_n(reset_n), .din(din), .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .dout(dout_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready)
  );
  audio_fir_decim #(.COEFFS(C_STEP)) u_step (
    .clock(clock), .reset_n(reset_n), .din(din), .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .dout(dout_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready)
  );
  audio_fir_decim #(.COEFFS(C_IMP)) u_imp (
    .clock(clock), .reset_n(reset_n), .din(din), .in_valid(in_valid), .in_ready(in_ready_a[2]),
    .dout(dout_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready)
  );
  audio_fir_decim #(.COEFFS(C_RND)) u_rnd (
    .clock(clock), .reset_n(reset_n), .din(din), .in_valid(in_valid), .in_ready(in_ready_a[3]),
    .dout(dout_a[3]), .out_valid(out_valid_a[3]), .out_ready(out_ready)
  );

  int checks, errors;
  int src_q[$];
  int acc_list[$];
  int n_out, ev_idx, gap_pct, sink_mode;
  bit ev_out;
  logic signed [DATA_WIDTH-1:0] ev_dout [NS];

  function automatic int coef(int s, int k);
    case (s)
      0:       return int'(AUDIO_LPR_COEFFS[k]);
      1:       return 1024;
      2:       return (k + 1) * 1024;
      default: return (k == 0) ? 512 : 0;
    endcase
  endfunction

  function automatic int dq(int v);
    return v / 1024;
  endfunction

  // y[n] = sum_k dq(trunc32(h[k] * x[n-k])), samples before the first one count as 0.
  function automatic int model_y(int s, int n);
    int y = 0;
    for (int k = 0; k < int'(MAX_TAPS); k++) begin
      int     x;
      longint p;
      x = (n - k >= 0) ? acc_list[n - k] : 0;
      p = longint'(coef(s, k)) * longint'(x);
      y += dq(int'(p));
    end
    return y;
  endfunction

  function automatic int rand_sample();
    if ($urandom_range(7) == 0) return int'($urandom);
    return int'($urandom_range(4095)) - 2048;
  endfunction

  // Advance one clock acting as upstream source and downstream sink.
  task automatic cycle();
    logic signed [DATA_WIDTH-1:0] d_cap [NS];
    bit fi, fo;
    if (!in_valid && src_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) in_valid = 1'b1;
    din = in_valid ? src_q[0] : '0;
    case (sink_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(1));
      default: out_ready = 1'b0;
    endcase
    fi = in_valid && in_ready_a[0];
    fo = out_valid_a[0] && out_ready;
    for (int s = 0; s < NS; s++) d_cap[s] = dout_a[s];
    @(posedge clock);
    #1;
    ev_out = fo;
    if (fi) begin
      acc_list.push_back(src_q.pop_front());
      in_valid = 1'b0;
    end
    if (fo) begin
      for (int s = 0; s < NS; s++) ev_dout[s] = d_cap[s];
      ev_idx = n_out;
      n_out++;
    end
  endtask

  task automatic do_reset(int n);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    din       = '0;
    out_ready = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b1;
    src_q.delete();
    acc_list.delete();
    n_out  = 0;
    ev_out = 0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    din       = 99;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      for (int s = 0; s < NS; s++) begin
        checks += 3;
        if (in_ready_a[s] !== 1'b0) begin
          errors++;
          $display("FAIL reset_in_ready set%0d: got %b expected 0", s, in_ready_a[s]);
        end
        if (out_valid_a[s] !== 1'b0) begin
          errors++;
          $display("FAIL reset_out_valid set%0d: got %b expected 0", s, out_valid_a[s]);
        end
        if (dout_a[s] !== '0) begin
          errors++;
          $display("FAIL reset_dout set%0d: got %0d expected 0", s, dout_a[s]);
        end
      end
    end
    reset_n  = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    for (int s = 0; s < NS; s++) begin
      checks++;
      if (in_ready_a[s] !== 1'b1 || out_valid_a[s] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset set%0d: got ready=%b valid=%b expected ready=1 valid=0", s,
                 in_ready_a[s], out_valid_a[s]);
      end
    end
  endtask

  task automatic test_step();
    int exp_v [6] = '{8192, 16384, 24576, 32768, 32768, 32768};
    int g, lat;
    do_reset(2);
    gap_pct   = 0;
    sink_mode = 0;
    repeat (48) src_q.push_back(1024);
    g = 0;
    while (acc_list.size() < 8 && g < 200) begin
      cycle();
      g++;
    end
    lat = 0;
    while (out_valid_a[1] !== 1'b1 && lat < 100) begin
      cycle();
      lat++;
    end
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL step_latency: got %0d cycles expected 33", lat);
    end
    g = 0;
    while (n_out < 6 && g < 1000) begin
      cycle();
      g++;
      if (ev_out) begin
        checks++;
        if (ev_dout[1] !== exp_v[ev_idx]) begin
          errors++;
          $display("FAIL step_out%0d: got %0d expected %0d", ev_idx, ev_dout[1], exp_v[ev_idx]);
        end
      end
    end
    checks++;
    if (n_out != 6) begin
      errors++;
      $display("FAIL step_timeout: got %0d outputs expected 6", n_out);
    end
  endtask

  task automatic test_impulse();
    int exp_v [6] = '{8192, 16384, 24576, 32768, 0, 0};
    int g;
    do_reset(2);
    gap_pct   = 0;
    sink_mode = 0;
    src_q.push_back(1024);
    repeat (47) src_q.push_back(0);
    g = 0;
    while (n_out < 6 && g < 1000) begin
      cycle();
      g++;
      if (ev_out) begin
        checks++;
        if (ev_dout[2] !== exp_v[ev_idx]) begin
          errors++;
          $display("FAIL impulse_out%0d: got %0d expected %0d", ev_idx, ev_dout[2], exp_v[ev_idx]);
        end
      end
    end
    checks++;
    if (n_out != 6) begin
      errors++;
      $display("FAIL impulse_timeout: got %0d outputs expected 6", n_out);
    end
  endtask

  task automatic test_rounding();
    int exp_v [2] = '{-1, 1};
    int g;
    do_reset(2);
    gap_pct   = 20;
    sink_mode = 0;
    repeat (7) src_q.push_back(0);
    src_q.push_back(-3);
    repeat (7) src_q.push_back(0);
    src_q.push_back(3);
    g = 0;
    while (n_out < 2 && g < 500) begin
      cycle();
      g++;
      if (ev_out) begin
        checks++;
        if (ev_dout[3] !== exp_v[ev_idx]) begin
          errors++;
          $display("FAIL round_out%0d: got %0d expected %0d", ev_idx, ev_dout[3], exp_v[ev_idx]);
        end
      end
    end
    checks++;
    if (n_out != 2) begin
      errors++;
      $display("FAIL round_timeout: got %0d outputs expected 2", n_out);
    end
  endtask

  task automatic test_backpressure();
    logic signed [DATA_WIDTH-1:0] hold [NS];
    logic signed [DATA_WIDTH-1:0] exp_v;
    int g;
    do_reset(2);
    gap_pct   = 0;
    sink_mode = 2;
    repeat (24) src_q.push_back(rand_sample());
    g = 0;
    while (out_valid_a[0] !== 1'b1 && g < 200) begin
      cycle();
      g++;
    end
    checks++;
    if (out_valid_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_valid: got %b expected 1", out_valid_a[0]);
    end
    for (int s = 0; s < NS; s++) hold[s] = dout_a[s];
    repeat (20) begin
      cycle();
      for (int s = 0; s < NS; s++) begin
        checks++;
        if (dout_a[s] !== hold[s] || out_valid_a[s] !== 1'b1 || in_ready_a[s] !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall set%0d: got dout=%0d valid=%b ready=%b expected %0d 1 0", s,
                   dout_a[s], out_valid_a[s], in_ready_a[s], hold[s]);
        end
      end
    end
    checks++;
    if (acc_list.size() != 8) begin
      errors++;
      $display("FAIL bp_accepted_during_stall: got %0d expected 8", acc_list.size());
    end
    sink_mode = 0;
    g = 0;
    while (n_out < 3 && g < 500) begin
      cycle();
      g++;
      if (ev_out) begin
        for (int s = 0; s < NS; s++) begin
          exp_v = model_y(s, (ev_idx + 1) * int'(AUDIO_DECIM) - 1);
          checks++;
          if (ev_dout[s] !== exp_v) begin
            errors++;
            $display("FAIL bp_out%0d set%0d: got %0d expected %0d", ev_idx, s, ev_dout[s], exp_v);
          end
        end
      end
    end
    checks++;
    if (n_out != 3 || acc_list.size() != 24 || src_q.size() != 0) begin
      errors++;
      $display("FAIL bp_totals: got outs=%0d accepted=%0d left=%0d expected 3 24 0", n_out,
               acc_list.size(), src_q.size());
    end
  endtask

  task automatic test_random_wrap();
    logic signed [DATA_WIDTH-1:0] exp_v;
    int g;
    do_reset(2);
    gap_pct   = 30;
    sink_mode = 1;
    repeat (800) src_q.push_back(rand_sample());
    g = 0;
    while (n_out < 100 && g < 30000) begin
      cycle();
      g++;
      if (ev_out) begin
        for (int s = 0; s < NS; s++) begin
          exp_v = model_y(s, (ev_idx + 1) * int'(AUDIO_DECIM) - 1);
          checks++;
          if (ev_dout[s] !== exp_v) begin
            errors++;
            $display("FAIL rand_out%0d set%0d: got %0d expected %0d", ev_idx, s, ev_dout[s],
                     exp_v);
          end
        end
      end
    end
    checks++;
    if (n_out != 100) begin
      errors++;
      $display("FAIL rand_timeout: got %0d outputs expected 100", n_out);
    end
  endtask

  task automatic test_mid_reset();
    logic signed [DATA_WIDTH-1:0] exp_v;
    bit spurious;
    int g;
    do_reset(2);
    gap_pct   = 0;
    sink_mode = 0;
    repeat (8) src_q.push_back(rand_sample() | 1);
    g = 0;
    while (acc_list.size() < 8 && g < 200) begin
      cycle();
      g++;
    end
    repeat (10) cycle();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    for (int s = 0; s < NS; s++) begin
      checks++;
      if (out_valid_a[s] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_valid set%0d: got %b expected 0", s, out_valid_a[s]);
      end
    end
    do_reset(1);
    spurious = 0;
    repeat (40) begin
      cycle();
      if (out_valid_a[0] !== 1'b0) spurious = 1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL midreset_stale_output: got out_valid=1 expected 0");
    end
    repeat (8) src_q.push_back(rand_sample());
    g = 0;
    while (n_out < 1 && g < 200) begin
      cycle();
      g++;
      if (ev_out) begin
        for (int s = 0; s < NS; s++) begin
          exp_v = model_y(s, int'(AUDIO_DECIM) - 1);
          checks++;
          if (ev_dout[s] !== exp_v) begin
            errors++;
            $display("FAIL midreset_fresh set%0d: got %0d expected %0d", s, ev_dout[s], exp_v);
          end
        end
      end
    end
    checks++;
    if (n_out != 1) begin
      errors++;
      $display("FAIL midreset_timeout: got %0d outputs expected 1", n_out);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    din       = '0;
    out_ready = 1'b0;
    gap_pct   = 0;
    sink_mode = 0;
    n_out     = 0;
    ev_idx    = 0;
    ev_out    = 0;
    test_reset();
    test_step();
    test_impulse();
    test_rounding();
    test_backpressure();
    test_random_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_fir_decim.md
# audio_fir_decim

Streaming decimating FIR filter for the audio path. It sits directly downstream of the FM demodulator, which emits Q10 samples at QUAD_RATE. It consumes that sample stream and emits one low-pass-filtered Q10 audio sample per AUDIO_DECIM inputs to the de-emphasis IIR stage. It uses a single time-shared multiplier, one tap per cycle, and a valid/ready handshake on both sides.

## Interface
- TAPS, default MAX_TAPS (32): filter length, must be a power of two.
- DECIM, default AUDIO_DECIM (8): decimation factor, 1 ≤ DECIM ≤ TAPS.
- COEFFS, default AUDIO_LPR_COEFFS: TAPS × DATA_WIDTH signed Q10 coefficients.
- clock  in  1  sole clock; everything on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- din  in  DATA_WIDTH  signed Q10 demodulated sample.
- in_valid  in  1  din valid.
- in_ready  out  1  block can accept din.
- dout  out  DATA_WIDTH  signed Q10 filtered, decimated sample.
- out_valid  out  1  dout valid.
- out_ready  in  1  downstream accepts dout.

## Operation
- History buffer: TAPS-entry circular register file `hist`, write pointer `wp` (log2 TAPS bits, wraps).
- Reset clears `hist`, `wp`, the sample counter and the accumulator, and sets state FILL.
- Reset values: in_ready=0 during reset, 1 in the first cycle after; out_valid=0; dout=0.
- FSM states:
  - FILL:
    - in_ready=1.
    - On in_valid&&in_ready: `hist[wp]<=din`, `wp<=wp+1`, `cnt<=cnt+1`.
    - When the DECIM-th sample is accepted (cnt==DECIM-1): clear cnt and acc, set tap index k=0, go to MAC.
  - MAC:
    - in_ready=0.
    - Each cycle: `acc <= acc + DEQUANTIZE_I(COEFFS[k] * hist[wp-1-k])`.
    - The index `wp-1-k` is taken mod TAPS; `hist[wp-1]` is the newest sample.
    - After k==TAPS-1: register dout<=final acc, out_valid<=1, go to OUT.
  - OUT:
    - in_ready=0; dout stable.
    - On out_ready: out_valid<=0, go to FILL.
- Result: y = Σ_{k=0}^{TAPS-1} DEQUANTIZE_I(h[k]·x[n−k]). Samples never received count as 0.
- Arithmetic:
  - Product is DATA_WIDTH×DATA_WIDTH signed, truncated to DATA_WIDTH before DEQUANTIZE_I.
  - DEQUANTIZE_I rounds toward zero.
  - acc is DATA_WIDTH signed and wraps on overflow; no saturation.
- No input is accepted outside FILL. The upstream stage holds din/in_valid until in_ready.
- in_valid is ignored while in_ready=0; such samples are neither dropped nor counted.
- Reset mid-MAC or mid-OUT aborts: out_valid drops and the history is cleared.

## Timing
- Input throughput: 1 sample/cycle in FILL.
- Latency: DECIM-th sample accepted at edge t → out_valid=1 after edge t+TAPS+1 (TAPS MAC cycles plus 1 register cycle).
- dout and out_valid change only on the state transitions above.
- A handshake completing in OUT returns to FILL. in_ready=1 from the next cycle; there is no combinational ready path.
- Sustained rate with out_ready=1: DECIM+TAPS+2 cycles per output (42 with defaults).

## Structure
- Add to GLOBALS: `AUDIO_LPR_COEFFS` (localparam array, MAX_TAPS × DATA_WIDTH).
- Use the existing GLOBALS items DATA_WIDTH, AUDIO_DECIM, MAX_TAPS, DEQUANTIZE_I. Add no new typedefs.
- Natural sub-module: `fir_mac`, a one-tap-per-cycle multiply/dequantize/accumulate datapath with clear/enable inputs.
- The FSM, history buffer and handshake live in the top module.

## Test plan
- **Reset:** hold reset_n=0 for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, dout=0; no sample is counted.
- **Step:** COEFFS all 1024, TAPS=32, DECIM=8; feed 1024 ×8 → dout=8192 at exactly 33 cycles after the 8th accept. Continue feeding 1024 → outputs 16384, 24576, 32768, then steady 32768.
- **Impulse:** COEFFS[k]=(k+1)·1024; feed 1024 then 0s → first output 8·1024=8192 (impulse at k=7). Subsequent outputs 16·1024, 24·1024, 32·1024, then 0.
- **Rounding:** COEFFS[0]=512, others 0; input −3 → DEQUANTIZE_I(−1536)=−1. Input 3 → 1.
- **Backpressure:** out_ready=0 for 20 cycles in OUT → dout stable, in_ready=0, upstream stall absorbed with no lost or duplicated samples. Compare against a scoreboard model.
- **Wrap and mid-reset:** run 100 outputs of random stimulus against a golden model to check `wp` wrap. Assert reset_n=0 during MAC → out_valid=0; the post-reset first output equals a fresh-filter result.
